mc_controller: RTL and testbench

Multi-cycle control unit for the ARM-subset processor. It replaces the single-cycle decoder with a Moore state machine that sequences one shared memory port and one ALU through fetch, decode, execute, memory and writeback cycles. It also holds the NZCV flag register and applies ARM condition codes. It sits inside `arm`, next to the multi-cycle datapath; imem and dmem are merged behind the single address mux that `AdrSrc` drives.

---
 rtl/mc_pkg.sv | 81 ++++++++
 rtl/mc_controller_cond_unit.sv | 30 +++
 rtl/mc_controller.sv | 160 ++++++++++++++++
 tb/tb_mc_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle ARM-subset control unit: FSM states,
// mux selects, ALU ops, condition codes and data-processing commands.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } mc_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // nzcv packs the flags as {N, Z, C, V}; 1111 falls through to "never".
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = ~z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = ~c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = ~n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = ~v;
            COND_HI: cond_holds = c & ~z;
            COND_LS: cond_holds = ~c | z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = ~z & (n == v);
            COND_LE: cond_holds = z | (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// NZCV flag register and condition evaluation; CondEx always reflects the
// stored flags, so an instruction never sees its own flag update.
module cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write,
    input  logic       cv_update,
    output logic       cond_ex
);

    logic [3:0] flags_reg;

    assign cond_ex = cond_holds(cond, flags_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= 4'b0000;
        end else if (flag_write && cond_ex) begin
            flags_reg[3:2] <= alu_flags[3:2];
            if (cv_update) begin
                flags_reg[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle Moore controller: sequences the shared memory port and ALU through
// fetch/decode/execute/memory/writeback and gates architectural writes by CondEx.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    mc_state_t state_reg;
    mc_state_t out_state;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       cond_ex;
    logic       dp_valid;
    logic [1:0] dp_alu;
    logic       flag_write;
    logic       cv_update;
    logic       pc_write_raw, reg_write_raw, mem_write_raw, ir_write_raw;
    logic       unused_instr_bits;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state_reg <= S_MEMADR;
                        OP_DP:   state_reg <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state_reg <= S_BRANCH;
                        default: state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_reg <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_reg <= S_MEMWB;
                S_EXECUTER: state_reg <= S_ALUWB;
                S_EXECUTEI: state_reg <= S_ALUWB;
                default:    state_reg <= S_FETCH;
            endcase
        end
    end

    assign State = state_reg;

    // Unknown commands run as ADD but never reach the register file.
    always_comb begin
        dp_valid = 1'b1;
        dp_alu   = ALU_ADD;
        case (cmd)
            CMD_ADD: dp_alu = ALU_ADD;
            CMD_SUB: dp_alu = ALU_SUB;
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            default: dp_valid = 1'b0;
        endcase
    end

    // During reset the mux selects present FETCH values regardless of state_reg.
    assign out_state = rst ? S_FETCH : state_reg;

    always_comb begin
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALUControl    = ALU_ADD;
        case (out_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = cond_ex;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = cond_ex;
                pc_write_raw  = cond_ex & rd_is_pc;
            end
            S_EXECUTER: ALUControl = dp_alu;
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
            end
            S_ALUWB: begin
                reg_write_raw = cond_ex & dp_valid;
                pc_write_raw  = cond_ex & dp_valid & rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB      = SRCB_IMM;
                ResultSrc    = RES_ALURESULT;
                pc_write_raw = cond_ex;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pc_write_raw  & ~rst;
    assign RegWrite = reg_write_raw & ~rst;
    assign MemWrite = mem_write_raw & ~rst;
    assign IRWrite  = ir_write_raw  & ~rst;

    assign ImmSrc    = op;
    assign RegSrc[0] = (op == OP_BR);
    assign RegSrc[1] = (op == OP_MEM) & ~funct[0];

    assign flag_write = ((state_reg == S_EXECUTER) || (state_reg == S_EXECUTEI))
                        && funct[0] && !rst;
    assign cv_update  = dp_valid && ((cmd == CMD_ADD) || (cmd == CMD_SUB));

    cond_unit u_cond_unit (
        .clk        (clk),
        .rst        (rst),
        .cond       (Instr[31:28]),
        .alu_flags  (ALUFlags),
        .flag_write (flag_write),
        .cv_update  (cv_update),
        .cond_ex    (cond_ex)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected per-cycle control words are queued
// per instruction and compared against the DUT one cycle at a time.
module tb_mc_controller;
    import mc_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  State;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
    //  ALUSrcB, ALUControl, ImmSrc, RegSrc}
    typedef logic [19:0] ctl_t;

    ctl_t       exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] cur_imm;
    logic [1:0] cur_rsrc;

    task automatic push(input string tag, input mc_state_t st, input logic pcw, input logic irw,
                        input logic rw, input logic mw, input logic adr, input logic [1:0] res,
                        input logic srca, input logic [1:0] srcb, input logic [1:0] alu);
        exp_q.push_back({st, pcw, irw, rw, mw, adr, res, srca, srcb, alu, cur_imm, cur_rsrc});
        tag_q.push_back(tag);
    endtask

    task automatic push_fetch(input string tag);
        push({tag, "/fetch"}, S_FETCH, 1, 1, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
    endtask

    task automatic push_decode(input string tag);
        push({tag, "/decode"}, S_DECODE, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
    endtask

    task automatic load(input logic [31:0] instr, input logic [1:0] imm, input logic [1:0] rsrc);
        Instr    = instr;
        cur_imm  = imm;
        cur_rsrc = rsrc;
    endtask

    // Compare mid-cycle, then move to just after the next rising edge.
    task automatic run_cycles(input int n);
        ctl_t  obs, want;
        string tag;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs  = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            n_checks++;
            assert (obs === want) n_pass++;
            else $error("FAIL %s: observed %05h expected %05h", tag, obs, want);
            $display("check %-16s observed %05h expected %05h", tag, obs, want);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        ALUFlags = 4'b0000;
        load(32'h0000_0000, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        push("reset", S_FETCH, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        run_cycles(1);
        rst = 1'b0;

        // ADD R8,R0,#5
        load(32'hE280_8005, 2'b00, 2'b00);
        push_fetch("addi"); push_decode("addi");
        push("addi/exei", S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("addi/aluwb", S_ALUWB, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        // LDR R1,[R0,#4]
        load(32'hE590_1004, 2'b01, 2'b00);
        push_fetch("ldr"); push_decode("ldr");
        push("ldr/memadr", S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("ldr/memread", S_MEMREAD, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        push("ldr/memwb", S_MEMWB, 0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00);
        run_cycles(5);

        // STR R1,[R0,#4]
        load(32'hE580_1004, 2'b01, 2'b10);
        push_fetch("str"); push_decode("str");
        push("str/memadr", S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("str/memwrite", S_MEMWRITE, 0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        // SUBS R0,R0,R0 with Z from the ALU sets the Z flag
        load(32'hE050_0000, 2'b00, 2'b00);
        ALUFlags = 4'b0100;
        push_fetch("subs"); push_decode("subs");
        push("subs/exer", S_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01);
        push("subs/aluwb", S_ALUWB, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);
        ALUFlags = 4'b0000;

        load(32'h0A00_0002, 2'b10, 2'b01);
        push_fetch("beq"); push_decode("beq");
        push("beq/branch", S_BRANCH, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
        run_cycles(3);

        load(32'h1A00_0002, 2'b10, 2'b01);
        push_fetch("bne"); push_decode("bne");
        push("bne/branch", S_BRANCH, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
        run_cycles(3);

        // ADDNE fails with Z=1: full path, no register write
        load(32'h1280_8005, 2'b00, 2'b00);
        push_fetch("addne"); push_decode("addne");
        push("addne/exei", S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("addne/aluwb", S_ALUWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        load(32'h0A00_0002, 2'b10, 2'b01);
        push_fetch("beq2"); push_decode("beq2");
        push("beq2/branch", S_BRANCH, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
        run_cycles(3);

        // ADDS R0,R0,#1 with ALU flags 0000 clears Z
        load(32'hE290_0001, 2'b00, 2'b00);
        push_fetch("adds"); push_decode("adds");
        push("adds/exei", S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("adds/aluwb", S_ALUWB, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        load(32'h1A00_0002, 2'b10, 2'b01);
        push_fetch("bne2"); push_decode("bne2");
        push("bne2/branch", S_BRANCH, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
        run_cycles(3);

        // Cond = 1111 never executes
        load(32'hF280_8005, 2'b00, 2'b00);
        push_fetch("nv"); push_decode("nv");
        push("nv/exei", S_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("nv/aluwb", S_ALUWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        // ORR R0,R0,R1
        load(32'hE180_0001, 2'b00, 2'b00);
        push_fetch("orr"); push_decode("orr");
        push("orr/exer", S_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b11);
        push("orr/aluwb", S_ALUWB, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
        run_cycles(4);

        // LDR PC,[R1,#4] also loads the PC in writeback
        load(32'hE591_F004, 2'b01, 2'b00);
        push_fetch("ldrpc"); push_decode("ldrpc");
        push("ldrpc/memadr", S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        push("ldrpc/memread", S_MEMREAD, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        push("ldrpc/memwb", S_MEMWB, 1, 0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00);
        run_cycles(5);

        // Op = 11 is a two-cycle NOP
        load(32'hEC00_0000, 2'b11, 2'b00);
        push_fetch("nop"); push_decode("nop");
        run_cycles(2);

        // Reset arriving in MEMWRITE suppresses the store and restarts at FETCH
        load(32'hE580_1004, 2'b01, 2'b10);
        push_fetch("strrst"); push_decode("strrst");
        push("strrst/memadr", S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        run_cycles(3);
        rst = 1'b1;
        push("strrst/memwrite", S_MEMWRITE, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        run_cycles(1);
        rst = 1'b0;
        push_fetch("strrst/after");
        run_cycles(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
